// File: rtl/uart_tx_fifo.sv
// UART transmitter (5-9 data bits, none/even/odd parity, 1-2 stop bits); `UART_TX_FIFO_EN selects a FIFO, else one holding register.
// Start bit falls one cycle after an idle accept; txReadyOUT low is the backpressure, loads while low are dropped and flagged.

`ifdef UART_TX_FIFO_EN
module uart_tx_fifo_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_vld,
   input  logic [WIDTH-1:0]       i_wr_dat,
   output logic                   o_wr_rdy,
   input  logic                   i_rd_rdy,
   output logic                   o_rd_vld,
   output logic [WIDTH-1:0]       o_rd_dat,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_wr_rdy = (r_count != (AW+1)'(DEPTH));
   assign o_rd_vld = (r_count != '0);
   assign o_rd_dat = r_mem[r_rptr];
   assign o_count  = r_count;
   assign w_wr     = i_wr_vld & o_wr_rdy;
   assign w_rd     = i_rd_rdy & o_rd_vld;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_wr_dat;
   end
endmodule
`endif

module uart_tx_fifo #(
   parameter int CLOCK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int DATA_BITS       = 8,
   parameter int PARITY          = 0,
   parameter int STOP_BITS       = 1,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                        clockIN,
   input  logic                        txResetIN,
   input  logic [DATA_BITS-1:0]        txDataIN,
   input  logic                        txLoadIN,
   output logic                        txReadyOUT,
   output logic                        txIdleOUT,
   output logic                        txOverflowOUT,
   output logic [$clog2(FIFO_DEPTH):0] txCountOUT,
   output logic                        txOUT
);
   localparam int BIT_CLKS = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int CW       = $clog2(BIT_CLKS);
   localparam int IW       = $clog2(DATA_BITS);
   localparam int CNTW     = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               r_state;
   logic [CW-1:0]        r_baud;
   logic [IW-1:0]        r_bit_idx;
   logic                 r_stop_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_tx;
   logic                 r_ovf;

   logic                 w_ready;
   logic                 w_head_vld;
   logic [DATA_BITS-1:0] w_head_dat;
   logic                 w_pop;
   logic                 w_par;

   // Pop when idle, or on the final edge of the last stop bit so frames run back to back.
   assign w_pop = w_head_vld &&
                  ((r_state == S_IDLE) ||
                   (r_state == S_STOP && r_baud == '0 && r_stop_idx == STOP_LAST));
   assign w_par = (PARITY == 2) ? ~(^w_head_dat) : ^w_head_dat;

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo_buf #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_buf (
      .i_clk    (clockIN),
      .i_rst    (txResetIN),
      .i_wr_vld (txLoadIN),
      .i_wr_dat (txDataIN),
      .o_wr_rdy (w_ready),
      .i_rd_rdy (w_pop),
      .o_rd_vld (w_head_vld),
      .o_rd_dat (w_head_dat),
      .o_count  (txCountOUT)
   );
`else
   logic                 r_hold_vld;
   logic [DATA_BITS-1:0] r_hold;
   logic                 w_wr;

   assign w_wr = txLoadIN & w_ready;

   // A write only lands when the register is empty, so it never collides with a pop.
   always_ff @(posedge clockIN) begin
      if (txResetIN) begin
         r_hold_vld <= 1'b0;
      end else if (w_wr) begin
         r_hold     <= txDataIN;
         r_hold_vld <= 1'b1;
      end else if (w_pop) begin
         r_hold_vld <= 1'b0;
      end
   end

   assign w_ready    = ~r_hold_vld;
   assign w_head_vld = r_hold_vld;
   assign w_head_dat = r_hold;
   assign txCountOUT = CNTW'(r_hold_vld);
`endif

   always_ff @(posedge clockIN) begin
      if (txResetIN) r_ovf <= 1'b0;
      else           r_ovf <= txLoadIN & ~w_ready;
   end

   always_ff @(posedge clockIN) begin
      if (txResetIN) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               if (w_pop) begin
                  r_state <= S_START;
                  r_baud  <= BIT_LAST;
                  r_shift <= w_head_dat;
                  r_par   <= w_par;
                  r_tx    <= 1'b0;
               end
            end
            S_START: begin
               if (r_baud != '0) begin
                  r_baud <= r_baud - 1'b1;
               end else begin
                  r_state   <= S_DATA;
                  r_baud    <= BIT_LAST;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
               end
            end
            S_DATA: begin
               if (r_baud != '0) begin
                  r_baud <= r_baud - 1'b1;
               end else if (r_bit_idx != IDX_LAST) begin
                  r_baud    <= BIT_LAST;
                  r_bit_idx <= r_bit_idx + 1'b1;
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
               end else if (PARITY != 0) begin
                  r_state <= S_PARITY;
                  r_baud  <= BIT_LAST;
                  r_tx    <= r_par;
               end else begin
                  r_state    <= S_STOP;
                  r_baud     <= BIT_LAST;
                  r_stop_idx <= 1'b0;
                  r_tx       <= 1'b1;
               end
            end
            S_PARITY: begin
               if (r_baud != '0) begin
                  r_baud <= r_baud - 1'b1;
               end else begin
                  r_state    <= S_STOP;
                  r_baud     <= BIT_LAST;
                  r_stop_idx <= 1'b0;
                  r_tx       <= 1'b1;
               end
            end
            S_STOP: begin
               if (r_baud != '0) begin
                  r_baud <= r_baud - 1'b1;
               end else if (r_stop_idx != STOP_LAST) begin
                  r_baud     <= BIT_LAST;
                  r_stop_idx <= 1'b1;
               end else if (w_pop) begin
                  r_state <= S_START;
                  r_baud  <= BIT_LAST;
                  r_shift <= w_head_dat;
                  r_par   <= w_par;
                  r_tx    <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_baud  <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign txOUT         = r_tx;
   assign txReadyOUT    = w_ready;
   assign txIdleOUT     = (r_state == S_IDLE) && !w_head_vld;
   assign txOverflowOUT = r_ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitters (8N1, 8E1, 8O1, 7N2 at 10 clocks/bit) checked every cycle against a frame-level model.
module tb_uart_tx_fifo;
   localparam int NDUT = 4;
   localparam int BC   = 10;
`ifdef UART_TX_FIFO_EN
   localparam int CAP  = 4;
`else
   localparam int CAP  = 1;
`endif

   function automatic int db_of(input int g);
      return (g == 3) ? 7 : 8;
   endfunction
   function automatic int par_of(input int g);
      return (g == 1) ? 1 : ((g == 2) ? 2 : 0);
   endfunction
   function automatic int sb_of(input int g);
      return (g == 3) ? 2 : 1;
   endfunction

   logic       clk = 1'b0;
   logic       rst;
   logic       load   [NDUT];
   logic [7:0] data   [NDUT];
   logic       tx_o   [NDUT];
   logic       rdy_o  [NDUT];
   logic       idle_o [NDUT];
   logic       ovf_o  [NDUT];
   logic [2:0] cnt_o  [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      uart_tx_fifo #(
         .CLOCK_FREQUENCY (100_000_000),
         .BAUD_RATE       (10_000_000),
         .DATA_BITS       (db_of(g)),
         .PARITY          (par_of(g)),
         .STOP_BITS       (sb_of(g)),
         .FIFO_DEPTH      (4)
      ) u_dut (
         .clockIN       (clk),
         .txResetIN     (rst),
         .txDataIN      (data[g][db_of(g)-1:0]),
         .txLoadIN      (load[g]),
         .txReadyOUT    (rdy_o[g]),
         .txIdleOUT     (idle_o[g]),
         .txOverflowOUT (ovf_o[g]),
         .txCountOUT    (cnt_o[g]),
         .txOUT         (tx_o[g])
      );
   end

   // Model: words waiting (pend), plus the frame on the wire as a bit vector and a cycle offset into it.
   int          pend  [NDUT][4];
   int          pcnt  [NDUT];
   bit          busy  [NDUT];
   int          cyc   [NDUT];
   logic [15:0] fbits [NDUT];
   bit          ovf_m [NDUT];
   bit          acc   [NDUT];
   bit          want  [NDUT];
   logic [7:0]  word  [NDUT];

   int n_cmp    = 0;
   int n_bad    = 0;
   int cycle_no = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cycle_no, got, exp);
      end
   endtask

   function automatic logic [15:0] frame_of(input int g, input int w);
      logic [15:0] f;
      int          db;
      bit          p;
      f  = '1;
      db = db_of(g);
      p  = 1'b0;
      f[0] = 1'b0;
      for (int k = 0; k < db; k++) begin
         f[1+k] = w[k];
         p      = p ^ w[k];
      end
      if (par_of(g) == 1) f[1+db] = p;
      if (par_of(g) == 2) f[1+db] = ~p;
      return f;
   endfunction

   function automatic int frame_cycles(input int g);
      return (1 + db_of(g) + ((par_of(g) != 0) ? 1 : 0) + sb_of(g)) * BC;
   endfunction

   task automatic model_step();
      for (int i = 0; i < NDUT; i++) begin
         bit rdy;
         acc[i] = 1'b0;
         if (rst) begin
            busy[i]  = 1'b0;
            pcnt[i]  = 0;
            cyc[i]   = 0;
            ovf_m[i] = 1'b0;
         end else begin
            rdy      = (pcnt[i] < CAP);
            ovf_m[i] = load[i] && !rdy;
            if (busy[i]) begin
               if (cyc[i] == frame_cycles(i) - 1) busy[i] = 1'b0;
               else                               cyc[i]++;
            end
            if (!busy[i] && pcnt[i] > 0) begin
               fbits[i] = frame_of(i, pend[i][0]);
               for (int k = 0; k < 3; k++) pend[i][k] = pend[i][k+1];
               pcnt[i]--;
               busy[i] = 1'b1;
               cyc[i]  = 0;
            end
            if (load[i] && rdy) begin
               pend[i][pcnt[i]] = int'(data[i]) & ((1 << db_of(i)) - 1);
               pcnt[i]++;
               acc[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < NDUT; i++) begin
         int exp_line;
         exp_line = busy[i] ? int'(fbits[i][cyc[i] / BC]) : 1;
         check_eq($sformatf("txOUT[%0d]", i),         int'(tx_o[i]),   exp_line);
         check_eq($sformatf("txCountOUT[%0d]", i),    int'(cnt_o[i]),  pcnt[i]);
         check_eq($sformatf("txReadyOUT[%0d]", i),    int'(rdy_o[i]),  (pcnt[i] < CAP) ? 1 : 0);
         check_eq($sformatf("txIdleOUT[%0d]", i),     int'(idle_o[i]), (!busy[i] && pcnt[i] == 0) ? 1 : 0);
         check_eq($sformatf("txOverflowOUT[%0d]", i), int'(ovf_o[i]),  int'(ovf_m[i]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      cycle_no++;
      @(negedge clk);
      check_outputs();
   endtask

   // Producer holds a word on txLoadIN until the model says it was taken.
   task automatic run_post(input int n);
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < NDUT; i++) begin
            load[i] = want[i];
            data[i] = word[i];
         end
         cycle();
         for (int i = 0; i < NDUT; i++) if (acc[i]) want[i] = 1'b0;
      end
      for (int i = 0; i < NDUT; i++) load[i] = 1'b0;
   endtask

   task automatic post_all(input logic [7:0] w);
      for (int i = 0; i < NDUT; i++) begin
         want[i] = 1'b1;
         word[i] = w;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
         load[i] = 1'b0;
         want[i] = 1'b0;
      end
      repeat (n) cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
         load[i]  = 1'b0;
         data[i]  = '0;
         want[i]  = 1'b0;
         word[i]  = '0;
         busy[i]  = 1'b0;
         pcnt[i]  = 0;
         cyc[i]   = 0;
         ovf_m[i] = 1'b0;
         fbits[i] = '1;
      end
      do_reset(2);

      post_all(8'hA5); run_post(140);
      post_all(8'h07); run_post(150);
      post_all(8'h7F); run_post(1);
      post_all(8'h00); run_post(300);

      for (int v = 1; v <= 6; v++) begin
         for (int i = 0; i < NDUT; i++) begin
            load[i] = 1'b1;
            data[i] = 8'(v);
         end
         cycle();
      end
      for (int i = 0; i < NDUT; i++) load[i] = 1'b0;
      run_post(800);

      post_all(8'h55); run_post(1);
      post_all(8'hAA); run_post(44);
      do_reset(1);
      run_post(200);

      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(2999, 0) == 0) do_reset(1);
         for (int i = 0; i < NDUT; i++) begin
            if (!want[i] && $urandom_range(15, 0) == 0) begin
               want[i] = 1'b1;
               word[i] = 8'($urandom);
            end
         end
         run_post(1);
      end
      run_post(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
